// File: rtl/updown_mod_counter.sv
// updown_mod_counter
// Modulo-MODULUS up/down counter with synchronous parallel load (clamped to
// the count range), a combinational terminal-count output for cascading and
// a registered completion flag. ONE_SHOT=0 gives a free-running counter that
// pulses DONE once per wrap; ONE_SHOT=1 runs an IDLE/RUN/FIN sequence that
// stops at the terminal value and holds DONE until the next load.
// Build option: define UPDOWN_MOD_COUNTER_CLR_EN to add the synchronous
// clear input CLR, which outranks LD and EN.
`timescale 1ns/1ps
module updown_mod_counter #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int ONE_SHOT = 0
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             EN,
    input  logic             UP,
    input  logic             LD,
`ifdef UPDOWN_MOD_COUNTER_CLR_EN
    input  logic             CLR,
`endif
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             DONE
);

    // MODULUS may equal 2^WIDTH, so range checks on D use one extra bit.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] Q_MAX   = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] Q_ZERO  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] Q_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] q_r;
    logic             done_r;

    logic             at_term_s;
    logic             tc_s;
    logic [WIDTH-1:0] load_val_s;
    logic [WIDTH-1:0] step_val_s;

    // Out-of-range load values saturate at the top of the count range.
    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] val);
        logic [WIDTH-1:0] res;
        if ({1'b0, val} < MOD_EXT) begin
            res = val;
        end else begin
            res = Q_MAX;
        end
        return res;
    endfunction

    // One modulo step; any value at or beyond the top is treated as the top
    // so the count can never leave 0..MODULUS-1.
    function automatic logic [WIDTH-1:0] count_step(input logic [WIDTH-1:0] cur,
                                                    input logic             dir_up);
        logic [WIDTH-1:0] res;
        if (dir_up) begin
            if (cur >= Q_MAX) begin
                res = Q_ZERO;
            end else begin
                res = cur + Q_ONE;
            end
        end else begin
            if (cur == Q_ZERO) begin
                res = Q_MAX;
            end else if (cur > Q_MAX) begin
                res = Q_MAX;
            end else begin
                res = cur - Q_ONE;
            end
        end
        return res;
    endfunction

    // Terminal-count detect plus the next-value candidates for load and step.
    always_comb begin
        at_term_s = 1'b0;
        if (UP) begin
            at_term_s = (q_r == Q_MAX);
        end else begin
            at_term_s = (q_r == Q_ZERO);
        end
        tc_s       = EN & at_term_s;
        load_val_s = clamp_load(D);
        step_val_s = count_step(q_r, UP);
    end

    // Count register, completion flag and one-shot sequencer.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            q_r     <= Q_ZERO;
            done_r  <= 1'b0;
            state_r <= ST_IDLE;
        end
`ifdef UPDOWN_MOD_COUNTER_CLR_EN
        else if (CLR) begin
            q_r     <= Q_ZERO;
            done_r  <= 1'b0;
            state_r <= ST_IDLE;
        end
`endif
        else if (LD) begin
            // A load never produces a completion, even with EN high.
            q_r     <= load_val_s;
            done_r  <= 1'b0;
            state_r <= ST_IDLE;
        end else if (ONE_SHOT != 0) begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (EN) begin
                        q_r     <= step_val_s;
                        state_r <= ST_RUN;
                    end else begin
                        q_r     <= q_r;
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (tc_s) begin
                        // Stop on the terminal value instead of wrapping.
                        q_r     <= q_r;
                        done_r  <= 1'b1;
                        state_r <= ST_FIN;
                    end else if (EN) begin
                        q_r     <= step_val_s;
                        done_r  <= 1'b0;
                        state_r <= ST_RUN;
                    end else begin
                        q_r     <= q_r;
                        done_r  <= 1'b0;
                        state_r <= ST_RUN;
                    end
                end
                ST_FIN: begin
                    // EN is ignored here; only a load (or reset) leaves FIN.
                    q_r     <= q_r;
                    done_r  <= 1'b1;
                    state_r <= ST_FIN;
                end
                default: begin
                    q_r     <= Q_ZERO;
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end else begin
            // Free-run: DONE follows the wrap edge for one cycle.
            state_r <= ST_IDLE;
            done_r  <= tc_s;
            if (EN) begin
                q_r <= step_val_s;
            end else begin
                q_r <= q_r;
            end
        end
    end

    assign Q    = q_r;
    assign TC   = tc_s;
    assign DONE = done_r;

endmodule

// File: tb/tb_updown_mod_counter.sv
// tb_updown_mod_counter
// Table-driven bench for updown_mod_counter (WIDTH=4, MODULUS=10): one
// free-run instance and one one-shot instance, each driven from its own
// vector table, plus hand-written asynchronous-reset and clear sequences.
`timescale 1ns/1ps
module tb_updown_mod_counter;

    localparam int W = 4;
    localparam int M = 10;

    typedef struct {
        logic         ld;
        logic         en;
        logic         up;
        logic [W-1:0] d;
        logic         clr;
        logic         chk_tc;
        logic         exp_tc;
        logic [W-1:0] exp_q;
        logic         exp_done;
    } vec_t;

    logic         CLK;
    logic         rn_fr, en_fr, up_fr, ld_fr;
    logic [W-1:0] d_fr, q_fr;
    logic         tc_fr, done_fr;
    logic         rn_os, en_os, up_os, ld_os;
    logic [W-1:0] d_os, q_os;
    logic         tc_os, done_os;
`ifdef UPDOWN_MOD_COUNTER_CLR_EN
    logic         clr_fr, clr_os;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    vec_t fr_tab[$];
    vec_t os_tab[$];

    updown_mod_counter #(.WIDTH(W), .MODULUS(M), .ONE_SHOT(0)) dut_fr (
        .CLK  (CLK),
        .RN   (rn_fr),
        .EN   (en_fr),
        .UP   (up_fr),
        .LD   (ld_fr),
`ifdef UPDOWN_MOD_COUNTER_CLR_EN
        .CLR  (clr_fr),
`endif
        .D    (d_fr),
        .Q    (q_fr),
        .TC   (tc_fr),
        .DONE (done_fr)
    );

    updown_mod_counter #(.WIDTH(W), .MODULUS(M), .ONE_SHOT(1)) dut_os (
        .CLK  (CLK),
        .RN   (rn_os),
        .EN   (en_os),
        .UP   (up_os),
        .LD   (ld_os),
`ifdef UPDOWN_MOD_COUNTER_CLR_EN
        .CLR  (clr_os),
`endif
        .D    (d_os),
        .Q    (q_os),
        .TC   (tc_os),
        .DONE (done_os)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic ld, input logic en, input logic up,
                                input logic [W-1:0] d, input logic clr,
                                input logic chk_tc, input logic exp_tc,
                                input logic [W-1:0] exp_q, input logic exp_done);
        vec_t v;
        v.ld = ld; v.en = en; v.up = up; v.d = d; v.clr = clr;
        v.chk_tc = chk_tc; v.exp_tc = exp_tc;
        v.exp_q = exp_q; v.exp_done = exp_done;
        return v;
    endfunction

    // Called one time unit after a rising edge: drive, check TC, clock, check Q/DONE.
    task automatic run_vec(input bit os, input string tag, input int idx, input vec_t v);
        if (os) begin
            ld_os = v.ld; en_os = v.en; up_os = v.up; d_os = v.d;
        end else begin
            ld_fr = v.ld; en_fr = v.en; up_fr = v.up; d_fr = v.d;
        end
`ifdef UPDOWN_MOD_COUNTER_CLR_EN
        if (os) clr_os = v.clr;
        else    clr_fr = v.clr;
`endif
        #1;
        if (v.chk_tc) check($sformatf("%s[%0d] TC", tag, idx), {31'd0, os ? tc_os : tc_fr}, {31'd0, v.exp_tc});
        @(posedge CLK);
        #1;
        check($sformatf("%s[%0d] Q", tag, idx), {28'd0, os ? q_os : q_fr}, {28'd0, v.exp_q});
        check($sformatf("%s[%0d] DONE", tag, idx), {31'd0, os ? done_os : done_fr}, {31'd0, v.exp_done});
    endtask

    initial begin
        // ---------------- free-run table ----------------
        for (int i = 0; i < 12; i++) begin
            fr_tab.push_back(mk(1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1, (i == 9) ? 1'b1 : 1'b0,
                                4'((i + 1) % 10), (i == 9) ? 1'b1 : 1'b0));
        end
        fr_tab.push_back(mk(1'b1, 1'b0, 1'b0, 4'd2,  1'b0, 1'b1, 1'b0, 4'd2, 1'b0));
        fr_tab.push_back(mk(1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 4'd1, 1'b0));
        fr_tab.push_back(mk(1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 4'd0, 1'b0));
        fr_tab.push_back(mk(1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 1'b1, 1'b1, 4'd9, 1'b1));
        fr_tab.push_back(mk(1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 4'd8, 1'b0));
        fr_tab.push_back(mk(1'b1, 1'b1, 1'b1, 4'd13, 1'b0, 1'b1, 1'b0, 4'd9, 1'b0));
        fr_tab.push_back(mk(1'b1, 1'b1, 1'b1, 4'd5,  1'b0, 1'b0, 1'b0, 4'd5, 1'b0));
        fr_tab.push_back(mk(1'b0, 1'b0, 1'b1, 4'd0,  1'b0, 1'b1, 1'b0, 4'd5, 1'b0));
        fr_tab.push_back(mk(1'b1, 1'b0, 1'b1, 4'd3,  1'b0, 1'b1, 1'b0, 4'd3, 1'b0));
        fr_tab.push_back(mk(1'b0, 1'b1, 1'b1, 4'd0,  1'b0, 1'b1, 1'b0, 4'd4, 1'b0));
        fr_tab.push_back(mk(1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 4'd3, 1'b0));
        fr_tab.push_back(mk(1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 4'd2, 1'b0));
        fr_tab.push_back(mk(1'b1, 1'b0, 1'b1, 4'd10, 1'b0, 1'b1, 1'b0, 4'd9, 1'b0));
        fr_tab.push_back(mk(1'b0, 1'b0, 1'b1, 4'd0,  1'b0, 1'b1, 1'b0, 4'd9, 1'b0));
        fr_tab.push_back(mk(1'b0, 1'b1, 1'b1, 4'd0,  1'b0, 1'b1, 1'b1, 4'd0, 1'b1));
        fr_tab.push_back(mk(1'b1, 1'b0, 1'b1, 4'd9,  1'b0, 1'b1, 1'b0, 4'd9, 1'b0));
        fr_tab.push_back(mk(1'b1, 1'b0, 1'b1, 4'd15, 1'b0, 1'b1, 1'b0, 4'd9, 1'b0));
        fr_tab.push_back(mk(1'b1, 1'b0, 1'b1, 4'd6,  1'b0, 1'b1, 1'b0, 4'd6, 1'b0));

        // ---------------- one-shot table ----------------
        for (int i = 0; i < 9; i++) begin
            os_tab.push_back(mk(1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 4'(i + 1), 1'b0));
        end
        os_tab.push_back(mk(1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1, 4'd9, 1'b1));
        os_tab.push_back(mk(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd9, 1'b1));
        os_tab.push_back(mk(1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1, 4'd9, 1'b1));
        os_tab.push_back(mk(1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0));
        os_tab.push_back(mk(1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0));
        os_tab.push_back(mk(1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0));
        os_tab.push_back(mk(1'b1, 1'b1, 1'b1, 4'd4, 1'b0, 1'b1, 1'b0, 4'd4, 1'b0));
        os_tab.push_back(mk(1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 4'd4, 1'b0));
        os_tab.push_back(mk(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd3, 1'b0));
        os_tab.push_back(mk(1'b1, 1'b0, 1'b1, 4'd8, 1'b0, 1'b1, 1'b0, 4'd8, 1'b0));
        os_tab.push_back(mk(1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 4'd9, 1'b0));
        os_tab.push_back(mk(1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1, 4'd9, 1'b1));

        // ---------------- reset ----------------
        rn_fr = 1'b0; en_fr = 1'b0; up_fr = 1'b1; ld_fr = 1'b0; d_fr = 4'd0;
        rn_os = 1'b0; en_os = 1'b0; up_os = 1'b1; ld_os = 1'b0; d_os = 4'd0;
`ifdef UPDOWN_MOD_COUNTER_CLR_EN
        clr_fr = 1'b0; clr_os = 1'b0;
`endif
        @(posedge CLK);
        #1;
        check("fr reset Q",    {28'd0, q_fr},    32'd0);
        check("fr reset DONE", {31'd0, done_fr}, 32'd0);
        check("os reset Q",    {28'd0, q_os},    32'd0);
        check("os reset DONE", {31'd0, done_os}, 32'd0);
        rn_fr = 1'b1;
        rn_os = 1'b1;

        // ---------------- tables ----------------
        for (int i = 0; i < fr_tab.size(); i++) run_vec(1'b0, "fr", i, fr_tab[i]);
        for (int i = 0; i < os_tab.size(); i++) run_vec(1'b1, "os", i, os_tab[i]);

        // ---------------- free-run: async reset between edges at Q=6 ----------------
        en_fr = 1'b0; ld_fr = 1'b0;
        #2;
        rn_fr = 1'b0;
        #1;
        check("fr async rst Q",    {28'd0, q_fr},    32'd0);
        check("fr async rst DONE", {31'd0, done_fr}, 32'd0);
        rn_fr = 1'b1;
        @(posedge CLK);
        #1;
        check("fr post-rst hold Q", {28'd0, q_fr}, 32'd0);
        run_vec(1'b0, "fr resume", 0, mk(1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0));

        // ---------------- one-shot: async reset in FIN ----------------
        en_os = 1'b0; ld_os = 1'b0;
        #2;
        rn_os = 1'b0;
        #1;
        check("os FIN rst Q",    {28'd0, q_os},    32'd0);
        check("os FIN rst DONE", {31'd0, done_os}, 32'd0);
        rn_os = 1'b1;
        @(posedge CLK);
        #1;
        check("os post-rst DONE", {31'd0, done_os}, 32'd0);
        check("os post-rst Q",    {28'd0, q_os},    32'd0);
        run_vec(1'b1, "os resume", 0, mk(1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0));

`ifdef UPDOWN_MOD_COUNTER_CLR_EN
        // ---------------- synchronous clear ----------------
        run_vec(1'b0, "fr clr", 0, mk(1'b1, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 4'd5, 1'b0));
        run_vec(1'b0, "fr clr", 1, mk(1'b1, 1'b1, 1'b1, 4'd7, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0));
        run_vec(1'b1, "os clr", 0, mk(1'b1, 1'b0, 1'b1, 4'd8, 1'b0, 1'b1, 1'b0, 4'd8, 1'b0));
        run_vec(1'b1, "os clr", 1, mk(1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 4'd9, 1'b0));
        run_vec(1'b1, "os clr", 2, mk(1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1, 4'd9, 1'b1));
        run_vec(1'b1, "os clr", 3, mk(1'b0, 1'b1, 1'b1, 4'd0, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0));
        run_vec(1'b1, "os clr", 4, mk(1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0));
        run_vec(1'b1, "os clr", 5, mk(1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/updown_mod_counter.md
UPDOWN_MOD_COUNTER -- requirements
Module: updown_mod_counter

Interface
REQ-001 Parameter WIDTH, default 4, counter width in bits; SHALL be at least 2.
REQ-002 Parameter MODULUS, default 16, count range 0..MODULUS-1; SHALL satisfy 2 <= MODULUS <= 2^WIDTH.
REQ-003 Parameter ONE_SHOT, default 0; 0 selects free-run mode, 1 selects one-shot mode.
REQ-004 CLK  input  1  single clock; all state SHALL update on the rising edge only.
REQ-005 RN  input  1  reset, asynchronous, active-low.
REQ-006 EN  input  1  count enable; one step per CLK edge while high.
REQ-007 UP  input  1  direction: 1 counts up, 0 counts down.
REQ-008 LD  input  1  synchronous parallel load strobe.
REQ-009 D  input  WIDTH  load value.
REQ-010 Q  output  WIDTH  registered count.
REQ-011 TC  output  1  combinational terminal count, for cascading.
REQ-012 DONE  output  1  registered completion flag.

Function
REQ-013 Per-edge priority SHALL be: LD, then EN count, then hold.
REQ-014 LD SHALL load Q <= D when D < MODULUS; otherwise Q <= MODULUS-1 (clamp).
REQ-015 Count up SHALL step Q+1; at Q = MODULUS-1 it SHALL wrap to 0 (free-run).
REQ-016 Count down SHALL step Q-1; at Q = 0 it SHALL wrap to MODULUS-1 (free-run).
REQ-017 TC SHALL equal EN & ((UP & Q==MODULUS-1) | (~UP & Q==0)), with no register stage.
REQ-018 Free-run: DONE SHALL pulse high for exactly one cycle, on the edge after each edge on which TC=1 and LD=0.
REQ-019 One-shot FSM states: IDLE, RUN, FIN.
REQ-020 IDLE: Q SHALL hold; EN=1 SHALL move to RUN and apply the first step on the same edge.
REQ-021 RUN: steps per REQ-015/016, except that a step with TC=1 SHALL leave Q at its terminal value and move to FIN.
REQ-022 FIN: DONE SHALL be 1 and EN SHALL be ignored; LD SHALL load per REQ-014 and return to IDLE.
REQ-023 LD in IDLE or RUN SHALL load per REQ-014 and go to IDLE.
REQ-024 A UP change mid-count SHALL take effect on the next edge; no state reset is implied.
REQ-025 Simultaneous LD and EN SHALL perform the load only; neither TC nor DONE is generated by that edge.
REQ-026 Q SHALL never take a value of MODULUS or greater.

Reset
REQ-027 RN low SHALL immediately force Q=0, DONE=0 and FSM=IDLE, independent of CLK.
REQ-028 After RN deasserts, counting SHALL resume on the first CLK rising edge with EN=1.
REQ-029 RN asserted mid-count or in FIN SHALL abort the operation with no residual DONE pulse.

Configuration
REQ-030 Macro UPDOWN_MOD_COUNTER_CLR_EN SHALL add a 1-bit input port CLR, a synchronous clear.
REQ-031 With the macro defined, CLR=1 SHALL force Q=0, DONE=0 and FSM=IDLE on the edge; CLR SHALL take priority over LD and EN.
REQ-032 Without the macro, the CLR port and its logic SHALL be absent, and behaviour SHALL be per REQ-013 to REQ-029.

Verification (WIDTH=4, MODULUS=10 unless stated)
REQ-033 Free-run up: RN pulse low, then EN=1 and UP=1 for 12 edges -> Q = 1..9,0,1,2. TC=1 while Q=9. DONE=1 for exactly the cycle after the 9->0 edge.
REQ-034 Free-run down: LD with D=2, then EN=1 and UP=0 for 4 edges -> Q = 2,1,0,9,8. TC=1 while Q=0.
REQ-035 Load clamp and priority: LD=1, EN=1, D=13 -> Q=9, no DONE. Then LD=1, D=5 -> Q=5.
REQ-036 One-shot (ONE_SHOT=1) sequence:
 - EN=1, UP=1 from reset -> Q reaches 9 and stays 9.
 - DONE=1 from the edge after the 8->9 step.
 - EN is ignored while in FIN.
 - LD with D=0 -> Q=0, DONE=0, FSM back to IDLE.
REQ-037 Async reset: RN driven low between edges at Q=6 -> Q=0 and DONE=0 before the next edge. Direction toggle UP 1->0 at Q=4 -> next Q=3.
REQ-038 With UPDOWN_MOD_COUNTER_CLR_EN defined: CLR=1, LD=1, D=7 at Q=5 -> Q=0. In one-shot FIN, CLR -> DONE=0 and FSM=IDLE.
